// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: per-bit synchronizer and saturating-count debouncer,
// with a one-cycle change strobe and a sticky, acknowledged change-event mask.
module switch_conditioner #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_COUNT    = 200
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] switch_db,
   output logic             db_changed,
   output logic [WIDTH-1:0] changed_mask,
   output logic             event_req,
   output logic [WIDTH-1:0] event_mask,
   input  logic             event_ack
);

   localparam int unsigned CNT_W = $clog2(DB_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]                  db_q, db_d;
   logic [WIDTH-1:0]                  chg_q;
   logic                              chg_any_q;
   logic [WIDTH-1:0]                  ev_q, ev_d;
   logic                              req_q;
   logic [WIDTH-1:0]                  samp;
   logic [WIDTH-1:0]                  flips;

   assign samp = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= switch;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   // Any sample agreeing with the stable level restarts that bit's count.
   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (samp[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]  = samp[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      flips = db_q ^ db_d;
      // New flips are OR'd in after the ack clear so they survive a coincident ack.
      ev_d  = (event_ack ? '0 : ev_q) | flips;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         db_q      <= '0;
         chg_q     <= '0;
         chg_any_q <= 1'b0;
         ev_q      <= '0;
         req_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         chg_q     <= flips;
         chg_any_q <= |flips;
         ev_q      <= ev_d;
         req_q     <= |ev_d;
      end
   end

   assign switch_db    = db_q;
   assign changed_mask = chg_q;
   assign db_changed   = chg_any_q;
   assign event_mask   = ev_q;
   assign event_req    = req_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner (SYNC_STAGES=2, DB_COUNT=4): stimulus
// queues expected strobes, an independent monitor checks each one as it appears.
module tb_switch_conditioner;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sw    = '0;
   logic        ack   = 1'b0;
   logic [15:0] switch_db, changed_mask, event_mask;
   logic        db_changed, event_req;

   switch_conditioner #(
      .WIDTH(16),
      .SYNC_STAGES(2),
      .DB_COUNT(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .switch(sw),
      .switch_db(switch_db),
      .db_changed(db_changed),
      .changed_mask(changed_mask),
      .event_req(event_req),
      .event_mask(event_mask),
      .event_ack(ack)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [15:0] mask;
      logic [15:0] db;
   } exp_t;

   exp_t sbq[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compares every strobe the DUT presents against the queue head.
   always @(posedge clock) begin : monitor
      exp_t e;
      #1;
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         n_total++;
         $display("FAIL strobe_missing: no strobe seen, expected at cyc %0d mask %h", sbq[0].cyc, sbq[0].mask);
         void'(sbq.pop_front());
      end
      if (db_changed) begin
         if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_strobe: cyc %0d mask %h db %h, expected no strobe", cyc, changed_mask, switch_db);
         end else begin
            e = sbq.pop_front();
            chk("strobe_cyc", 32'(cyc), 32'(e.cyc));
            chk("changed_mask", 32'(changed_mask), 32'(e.mask));
            chk("strobe_switch_db", 32'(switch_db), 32'(e.db));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at a negedge; a nonzero mask means a strobe is due 6 posedges later.
   task automatic drive(input logic [15:0] v, input logic [15:0] mask);
      sw = v;
      if (mask != 16'h0) sbq.push_back(exp_t'{cyc + 6, mask, v});
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step(1);
      ack = 1'b0;
   endtask

   initial begin
      #2 reset = 1'b0;
      sw = 16'hFFFF;
      step(3);
      chk("rst_switch_db", 32'(switch_db), 32'h0);
      chk("rst_changed_mask", 32'(changed_mask), 32'h0);
      chk("rst_db_changed", 32'(db_changed), 32'h0);
      chk("rst_event_mask", 32'(event_mask), 32'h0);
      chk("rst_event_req", 32'(event_req), 32'h0);

      reset = 1'b1;
      drive(16'hFFFF, 16'hFFFF);
      step(7);
      chk("post_rst_event_mask", 32'(event_mask), 32'hFFFF);
      chk("post_rst_event_req", 32'(event_req), 32'h1);
      pulse_ack();
      chk("ack_event_mask", 32'(event_mask), 32'h0);
      chk("ack_event_req", 32'(event_req), 32'h0);

      drive(16'h0000, 16'hFFFF);
      step(8);
      pulse_ack();

      drive(16'h0008, 16'h0008);
      step(8);
      chk("toggle_switch_db", 32'(switch_db), 32'h0008);
      pulse_ack();

      drive(16'h0088, 16'h0000);
      step(3);
      drive(16'h0008, 16'h0000);
      step(20);
      chk("glitch_switch_db", 32'(switch_db), 32'h0008);
      chk("glitch_event_mask", 32'(event_mask), 32'h0);
      chk("glitch_event_req", 32'(event_req), 32'h0);

      drive(16'h0088, 16'h0080);
      step(4);
      drive(16'h0008, 16'h0080);
      step(10);
      chk("pulse4_switch_db", 32'(switch_db), 32'h0008);
      pulse_ack();

      for (int i = 0; i < 10; i++) begin
         drive((i % 2 == 0) ? 16'h0009 : 16'h0008, 16'h0000);
         step(1);
      end
      drive(16'h0009, 16'h0001);
      step(8);
      chk("bounce_switch_db", 32'(switch_db), 32'h0009);
      pulse_ack();

      drive(16'h000B, 16'h0002);
      step(8);
      drive(16'h000F, 16'h0004);
      step(8);
      chk("hs_event_mask", 32'(event_mask), 32'h0006);
      chk("hs_event_req", 32'(event_req), 32'h1);
      drive(16'h002F, 16'h0020);
      step(5);
      pulse_ack();
      chk("hs_coinc_event_mask", 32'(event_mask), 32'h0020);
      chk("hs_coinc_event_req", 32'(event_req), 32'h1);
      pulse_ack();
      chk("hs_clear_event_mask", 32'(event_mask), 32'h0);
      chk("hs_clear_event_req", 32'(event_req), 32'h0);

      drive(16'h022F, 16'h0000);
      step(4);
      reset = 1'b0;
      #1;
      chk("midrst_switch_db", 32'(switch_db), 32'h0);
      chk("midrst_db_changed", 32'(db_changed), 32'h0);
      chk("midrst_changed_mask", 32'(changed_mask), 32'h0);
      chk("midrst_event_mask", 32'(event_mask), 32'h0);
      step(2);
      reset = 1'b1;
      drive(16'h022F, 16'h022F);
      step(8);
      chk("midrst_after_switch_db", 32'(switch_db), 32'h022F);

      step(5);
      chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
